l1_l2_arbiter: RTL

- Two-port arbiter between the L1 instruction cache and the L1 data cache. Both L1s miss into the single shared L2 cache; this block sits directly upstream of the L2 cache.
- Grants one L1 at a time and latches that request's address and write line.
- Drives the L2 request until the L2 responds, then routes the response back to the granted L1 only.
- Uses round-robin on contention so neither L1 starves.

---
 rtl/l1_l2_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/l1_l2_arbiter.sv
// Round-robin arbiter that funnels I-cache and D-cache line misses into one L2.
// A grant latches the winning request, which is then held on the L2 port until l2_resp.
module l1_l2_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [LINE_WIDTH-1:0] i_wdata,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [ADDR_WIDTH-1:0] l2_address,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  input  logic [LINE_WIDTH-1:0] l2_rdata,
  input  logic                  l2_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t                state_reg, state_next;
  logic                  last_grant_reg, last_grant_next;  // 0 = I, 1 = D
  logic                  lat_read_reg, lat_read_next;
  logic                  lat_write_reg, lat_write_next;
  logic [ADDR_WIDTH-1:0] lat_address_reg, lat_address_next;
  logic [LINE_WIDTH-1:0] lat_wdata_reg, lat_wdata_next;

  logic i_req, d_req, grant_i, grant_d;

  // A port asserting both read and write is malformed and never wins.
  assign i_req   = i_read ^ i_write;
  assign d_req   = d_read ^ d_write;
  assign grant_i = i_req && (!d_req || last_grant_reg);
  assign grant_d = d_req && (!i_req || !last_grant_reg);

  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

  always_comb begin
    state_next       = state_reg;
    last_grant_next  = last_grant_reg;
    lat_read_next    = lat_read_reg;
    lat_write_next   = lat_write_reg;
    lat_address_next = lat_address_reg;
    lat_wdata_next   = lat_wdata_reg;
    l2_read          = 1'b0;
    l2_write         = 1'b0;
    l2_address       = '0;
    l2_wdata         = '0;
    i_resp           = 1'b0;
    d_resp           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (grant_i) begin
          state_next       = SERVE_I;
          last_grant_next  = 1'b0;
          lat_read_next    = i_read;
          lat_write_next   = i_write;
          lat_address_next = i_address;
          lat_wdata_next   = i_wdata;
        end else if (grant_d) begin
          state_next       = SERVE_D;
          last_grant_next  = 1'b1;
          lat_read_next    = d_read;
          lat_write_next   = d_write;
          lat_address_next = d_address;
          lat_wdata_next   = d_wdata;
        end
      end
      SERVE_I, SERVE_D: begin
        l2_read    = lat_read_reg;
        l2_write   = lat_write_reg;
        l2_address = lat_address_reg;
        l2_wdata   = lat_wdata_reg;
        if (l2_resp) begin
          state_next = IDLE;
          // The L2 is reset alongside us, so a completion during reset is dropped.
          i_resp     = (state_reg == SERVE_I) && !reset;
          d_resp     = (state_reg == SERVE_D) && !reset;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      last_grant_reg  <= 1'b1;
      lat_read_reg    <= 1'b0;
      lat_write_reg   <= 1'b0;
      lat_address_reg <= '0;
      lat_wdata_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      last_grant_reg  <= last_grant_next;
      lat_read_reg    <= lat_read_next;
      lat_write_reg   <= lat_write_next;
      lat_address_reg <= lat_address_next;
      lat_wdata_reg   <= lat_wdata_next;
    end
  end

endmodule
